instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, setting the width of in_imm.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, setting the width of both counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request carries a field set to encode.
REQ-006 in_ready  output  1  encoder accepts a request this cycle.
REQ-007 in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-008 in_opcode  input  7  opcode bits [6:0].
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-010 in_funct3  input  3  funct3; in_funct7  input  7  funct7.
REQ-011 in_imm  input  DATA_WIDTH  signed immediate (U: full upper value; B/J: byte offset).
REQ-012 out_valid  output  1  out_instr and out_err are valid.
REQ-013 out_ready  input  1  consumer takes the head word this cycle.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_err  output  1  head word came from an illegal format or an unrepresentable immediate.
REQ-016 enc_count  output  CNT_WIDTH  number of accepted requests, wrapping.
REQ-017 err_count  output  CNT_WIDTH  number of accepted erroneous requests, saturating at all-ones.

Function
REQ-018 Request transfer SHALL occur on an edge with in_valid=1 and in_ready=1; output transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-019 Encoded words SHALL pass through a 2-entry FIFO; in_ready SHALL equal (entries<2) and SHALL NOT depend combinationally on out_ready.
REQ-020 Latency: a word accepted at edge N SHALL appear with out_valid=1 after edge N if the FIFO was empty; FIFO order SHALL be preserved.
REQ-021 Simultaneous push and pop SHALL leave the occupancy unchanged; pop on empty and push on full SHALL NOT occur.
REQ-022 Field packing SHALL follow RV32 base formats: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]|rs1|funct3|rd|opcode; S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-023 Field packing continued: B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; U = imm[31:12]|rd|opcode; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-024 An illegal in_fmt (6 or 7) SHALL encode 0x00000013 (NOP) with out_err=1.
REQ-025 enc_count SHALL increment on every request transfer; err_count SHALL increment on every request transfer whose word has err=1, saturating at all-ones.

Reset
REQ-026 While rst=1 at an edge: FIFO emptied, out_valid=0, in_ready=1 after the edge, out_instr=0, out_err=0, enc_count=0, err_count=0.
REQ-027 Reset mid-operation SHALL discard buffered words without emitting them; a request presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-028 Macro IMM_RANGE_CHECK_EN: when defined, err SHALL also be set when the immediate is not representable in its format.
REQ-029 Representable ranges: I and S need in_imm in [-2048, 2047]; B needs in_imm in [-4096, 4094] with bit0=0; J needs in_imm in [-2^20, 2^20-2] with bit0=0; U needs in_imm[11:0]=0 and in_imm sign-extendable from bit 31. R is never flagged.
REQ-030 When IMM_RANGE_CHECK_EN is undefined, immediates SHALL be silently truncated, and out_err and err_count SHALL reflect only illegal formats.

Verification
REQ-031 I: opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093, err 0; imm=-1 -> 0xFFF00093.
REQ-032 S: opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> out_instr 0x0020A423.
REQ-033 B: opcode=0x63, funct3=0, rs1=0, rs2=0, imm=-4 -> out_instr 0xFE000EE3.
REQ-034 I with imm=2048, check macro defined -> out_err=1 and err_count +1; same stimulus with the macro undefined -> out_err=0. in_fmt=7 -> 0x00000013 with out_err=1 in both builds.
REQ-035 out_ready=0 with three back-to-back requests -> in_ready=0 after the second transfer; then out_ready=1 -> words emerge in order, enc_count=3.
REQ-036 Reset asserted with 2 words buffered -> out_valid=0 and both counters 0 after the edge; the discarded words are never emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Packs a set of RV32 instruction fields (format, opcode, register numbers,
//   funct3/funct7 and a signed immediate) into a 32-bit instruction word.
//   Encoded words are buffered in a 2-entry FIFO with valid/ready handshakes
//   on both sides. An illegal format encodes a NOP (0x00000013) and sets the
//   error flag that travels with the word.
//
//   The encoder also keeps two counters:
//     - enc_count: accepted requests, wrapping.
//     - err_count: accepted erroneous requests, saturating at all-ones.
//
// Configuration:
//   IMM_RANGE_CHECK_EN - when defined, an immediate that is not representable
//                        in its format also sets the error flag. When it is
//                        undefined, immediates are silently truncated and
//                        only illegal formats are flagged.
//
// Ports:
//   clk        in   1           clock, all state updates on the rising edge
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           request carries a field set to encode
//   in_ready   out  1           encoder accepts a request this cycle
//   in_fmt     in   3           0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode  in   7           opcode bits [6:0]
//   in_rd      in   5           destination register
//   in_rs1     in   5           source register 1
//   in_rs2     in   5           source register 2
//   in_funct3  in   3           funct3 field
//   in_funct7  in   7           funct7 field
//   in_imm     in   DATA_WIDTH  signed immediate (U: full upper value,
//                               B/J: byte offset)
//   out_valid  out  1           out_instr / out_err hold a valid word
//   out_ready  in   1           consumer takes the head word this cycle
//   out_instr  out  32          encoded instruction word
//   out_err    out  1           head word is erroneous
//   enc_count  out  CNT_WIDTH   accepted requests, wrapping
//   err_count  out  CNT_WIDTH   accepted erroneous requests, saturating
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  enc_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    // Format codes
    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // -------------------------------------------------------------------------
    // Immediate normalised to 32 bits: narrower inputs are sign-extended,
    // wider inputs are truncated (the range check, if enabled, looks at the
    // full-width value instead).
    // -------------------------------------------------------------------------
    logic [31:0] w_imm32;

    generate
        if (DATA_WIDTH >= 32) begin : g_imm_trunc
            assign w_imm32 = in_imm[31:0];
        end else begin : g_imm_sext
            assign w_imm32 = {{(32 - DATA_WIDTH){in_imm[DATA_WIDTH-1]}}, in_imm};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Encoder datapath
    // -------------------------------------------------------------------------
    logic [31:0] w_word;
    logic        w_fmt_illegal;
    logic        w_range_err;
    logic        w_err;

    // Field packing for each base format; illegal formats fall back to a NOP.
    always_comb begin
        w_word        = NOP_WORD;
        w_fmt_illegal = 1'b0;
        case (in_fmt)
            FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: w_word = {w_imm32[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: w_word = {w_imm32[11:5], in_rs2, in_rs1, in_funct3,
                             w_imm32[4:0], in_opcode};
            FMT_B: w_word = {w_imm32[12], w_imm32[10:5], in_rs2, in_rs1, in_funct3,
                             w_imm32[4:1], w_imm32[11], in_opcode};
            FMT_U: w_word = {w_imm32[31:12], in_rd, in_opcode};
            FMT_J: w_word = {w_imm32[20], w_imm32[10:1], w_imm32[11],
                             w_imm32[19:12], in_rd, in_opcode};
            default: begin
                w_word        = NOP_WORD;
                w_fmt_illegal = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Work at least 33 bits wide so the U-format "fits in a signed 32-bit
    // value" test and all range bounds are exact for any DATA_WIDTH.
    localparam int EW = (DATA_WIDTH > 33) ? DATA_WIDTH : 33;

    localparam logic signed [EW-1:0] LIM12_LO = EW'(-2048);
    localparam logic signed [EW-1:0] LIM12_HI = EW'(2047);
    localparam logic signed [EW-1:0] LIMB_LO  = EW'(-4096);
    localparam logic signed [EW-1:0] LIMB_HI  = EW'(4094);
    localparam logic signed [EW-1:0] LIMJ_LO  = EW'(-1048576);
    localparam logic signed [EW-1:0] LIMJ_HI  = EW'(1048574);

    logic signed [EW-1:0] w_imm_x;

    assign w_imm_x = EW'($signed(in_imm));

    // Inclusive signed range test.
    function automatic logic in_range(input logic signed [EW-1:0] v,
                                      input logic signed [EW-1:0] lo,
                                      input logic signed [EW-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Bits [EW-1:31] all equal means the value sign-extends from bit 31.
    function automatic logic fits_s32(input logic signed [EW-1:0] v);
        return (&v[EW-1:31]) | ~(|v[EW-1:31]);
    endfunction

    // Flags immediates that cannot be represented in the selected format.
    always_comb begin
        w_range_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: w_range_err = ~in_range(w_imm_x, LIM12_LO, LIM12_HI);
            FMT_B:        w_range_err = ~in_range(w_imm_x, LIMB_LO, LIMB_HI) | w_imm_x[0];
            FMT_J:        w_range_err = ~in_range(w_imm_x, LIMJ_LO, LIMJ_HI) | w_imm_x[0];
            FMT_U:        w_range_err = (w_imm_x[11:0] != 12'd0) | ~fits_s32(w_imm_x);
            default:      w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_err = w_fmt_illegal | w_range_err;

    // -------------------------------------------------------------------------
    // 2-entry FIFO built as a head register (drives the outputs directly) and
    // a tail register. in_ready only looks at the tail occupancy, so it never
    // depends combinationally on out_ready.
    // -------------------------------------------------------------------------
    logic        r_head_valid;
    logic [31:0] r_head_instr;
    logic        r_head_err;
    logic        r_tail_valid;
    logic [31:0] r_tail_instr;
    logic        r_tail_err;

    logic        w_push;
    logic        w_pop;

    assign in_ready  = ~r_tail_valid;
    assign out_valid = r_head_valid;
    assign out_instr = r_head_instr;
    assign out_err   = r_head_err;

    assign w_push = in_valid & ~r_tail_valid;
    assign w_pop  = r_head_valid & out_ready;

    // FIFO storage and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_instr <= 32'd0;
            r_head_err   <= 1'b0;
            r_tail_valid <= 1'b0;
            r_tail_instr <= 32'd0;
            r_tail_err   <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_valid) begin
                // Full: no push is possible, tail advances to head.
                r_head_instr <= r_tail_instr;
                r_head_err   <= r_tail_err;
                r_tail_valid <= 1'b0;
            end else if (w_push) begin
                // One entry, pop and push together: new word replaces head.
                r_head_instr <= w_word;
                r_head_err   <= w_err;
            end else begin
                r_head_valid <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_head_valid) begin
                r_head_valid <= 1'b1;
                r_head_instr <= w_word;
                r_head_err   <= w_err;
            end else begin
                r_tail_valid <= 1'b1;
                r_tail_instr <= w_word;
                r_tail_err   <= w_err;
            end
        end else begin
            r_head_valid <= r_head_valid;
            r_tail_valid <= r_tail_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_enc_count;
    logic [CNT_WIDTH-1:0] r_err_count;

    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

    // Accepted-request counter wraps; error counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_push) begin
            r_enc_count <= r_enc_count + CNT_ONE;
            if (w_err && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_enc_count <= r_enc_count;
            r_err_count <= r_err_count;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Scoreboard bench for instr_encoder. The driver pushes the hand-computed
// word/err pair into a queue when a request is accepted; an independent
// monitor pops and compares whenever the DUT hands a word to the consumer.
// Error expectations depend on whether IMM_RANGE_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    instr_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] exp_enc  = 16'd0;
    logic [15:0] exp_errc = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a word transfers at the next rising edge when both flags are high.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%08h, expected no word", out_instr);
            end else begin
                e = sb_q.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            end
        end
    end

    // Issue one request; wait (bounded) for acceptance, then log expectation.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_w, input logic err_nochk,
                        input logic err_chk, input bit track);
        logic e;
        bit   got;
        exp_t item;
`ifdef IMM_RANGE_CHECK_EN
        e = err_chk;
`else
        e = err_nochk;
`endif
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 40 cycles");
        end else if (track) begin
            item.instr = exp_w;
            item.err   = e;
            sb_q.push_back(item);
            exp_enc = exp_enc + 16'd1;
            if (e) exp_errc = exp_errc + 16'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        chk({tag, "_enc_count"}, {16'd0, enc_count}, {16'd0, exp_enc});
        chk({tag, "_err_count"}, {16'd0, err_count}, {16'd0, exp_errc});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_enc  = 16'd0;
        exp_errc = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        repeat (2) @(posedge clk);
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);
        chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // fmt, op, rd, rs1, rs2, f3, f7, imm, expected word, err(nochk), err(chk)
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0, 1'b0, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0, 1'b1);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0, 1'b0, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 1'b0, 1'b1);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h7FFFFFFF, 32'h002081B3, 1'b0, 1'b0, 1'b1);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h402081B3, 1'b0, 1'b0, 1'b1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0, 1'b0, 1'b1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b0, 1'b1, 1'b1);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h001000EF, 1'b0, 1'b0, 1'b1);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0, 1'b0, 1'b1);
        send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b0, 1'b1, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h80000093, 1'b0, 1'b1, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0, 1'b0, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0, 1'b0, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0, 1'b0, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     32'h80000063, 1'b0, 1'b1, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        32'h00000163, 1'b0, 1'b1, 1'b1);
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd7, 7'h7F, 32'd5,        32'h00000013, 1'b1, 1'b1, 1'b1);
        send(3'd6, 7'h13, 5'd9, 5'd4, 5'd6, 3'd1, 7'h01, 32'hFFFFFFFF, 32'h00000013, 1'b1, 1'b1, 1'b1);
        drain();
        check_counters("burst");

        // Backpressure: two words fill the FIFO, third waits for the consumer.
        pulse_reset();
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h00100093, 1'b0, 1'b0, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h00200093, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_in_ready",  {31'd0, in_ready},  32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_head",      out_instr, 32'h00100093);
        @(posedge clk);
        #1;
        fork
            send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h00300093, 1'b0, 1'b0, 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_counters("bp");
        chk("bp_enc_is_3", {16'd0, enc_count}, 32'd3);

        // Reset with two buffered words and a request presented during reset.
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7, 32'h00700113, 1'b0, 1'b0, 1'b0);
        send(3'd7, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8, 32'h00000013, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        in_fmt = 3'd1; in_imm = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_enc  = 16'd0;
        exp_errc = 16'd0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_enc_count", {16'd0, enc_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
